// File: rtl/burst_ram_responder.sv
// Cycle-accurate stand-in for the PSRAM burst command interface: post-reset calibration,
// fixed read latency, 4-beat bursts and a minimum command interval. Optional byte masking: BURST_RAM_DATA_MASK_EN.
module burst_ram_responder #(
  parameter int DEPTH_BITWIDTH   = 21,
  parameter int BURST_BEATS      = 4,
  parameter int READ_LATENCY     = 6,
  parameter int COMMAND_INTERVAL = 14,
  parameter int INIT_CYCLES      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd,
  input  logic                      cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] addr,
  input  logic [63:0]               wr_data,
  input  logic [7:0]                data_mask,
  output logic [63:0]               rd_data,
  output logic                      rd_data_valid,
  output logic                      init_calib,
  output logic                      busy,
  output logic                      cmd_error
);

  localparam int DEPTH  = 2 ** DEPTH_BITWIDTH;
  localparam int BEAT_W = 3;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int IV_W   = $clog2(COMMAND_INTERVAL + 1);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_READ_WAIT   = 3'd2,
    ST_READ_BURST  = 3'd3,
    ST_WRITE_BURST = 3'd4
  } state_t;

  state_t                    state_r, state_next_s;
  logic [INIT_W-1:0]         init_cnt_r, init_cnt_next_s;
  logic [BEAT_W-1:0]         beat_r, beat_next_s;
  logic [LAT_W-1:0]          lat_r, lat_next_s;
  logic [IV_W-1:0]           interval_r, interval_next_s;
  logic [DEPTH_BITWIDTH-1:0] addr_r, addr_next_s;
  logic                      init_calib_r, init_calib_next_s;
  logic                      valid_r, valid_next_s;
  logic                      busy_r, busy_next_s;
  logic                      cmd_error_r, cmd_error_next_s;
  logic [63:0]               rd_data_r;
  logic                      accept_s;
  logic                      wr_en_s;
  logic [DEPTH_BITWIDTH-1:0] wr_addr_s;
  logic                      rd_en_s;
  logic [DEPTH_BITWIDTH-1:0] rd_addr_s;

  logic [63:0] mem_r [0:DEPTH-1];

`ifdef BURST_RAM_DATA_MASK_EN
  // data_mask bit 0 guards the most significant byte, bit 7 the least significant.
  function automatic logic [63:0] merge_masked(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  mask);
    logic [63:0] result;
    result = new_word;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        result[(7-i)*8 +: 8] = old_word[(7-i)*8 +: 8];
      end else begin
        result[(7-i)*8 +: 8] = new_word[(7-i)*8 +: 8];
      end
    end
    return result;
  endfunction
`else
  logic unused_mask_s;
  assign unused_mask_s = ^data_mask;
`endif

  // Next-state, counter and output decode for the command FSM.
  always_comb begin
    state_next_s      = state_r;
    init_cnt_next_s   = init_cnt_r;
    beat_next_s       = beat_r;
    lat_next_s        = lat_r;
    addr_next_s       = addr_r;
    init_calib_next_s = init_calib_r;
    valid_next_s      = valid_r;
    wr_en_s           = 1'b0;
    wr_addr_s         = addr;
    rd_en_s           = 1'b0;
    rd_addr_s         = addr_r;
    if (interval_r != {IV_W{1'b0}}) begin
      interval_next_s = interval_r - IV_W'(1);
    end else begin
      interval_next_s = interval_r;
    end
    accept_s = cmd_en && (state_r == ST_IDLE) && (interval_r == {IV_W{1'b0}});
    if (cmd_en && !accept_s) begin
      cmd_error_next_s = 1'b1;
    end else begin
      cmd_error_next_s = 1'b0;
    end

    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_W'(INIT_CYCLES - 1)) begin
          state_next_s      = ST_IDLE;
          init_calib_next_s = 1'b1;
        end else begin
          init_cnt_next_s = init_cnt_r + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          addr_next_s     = addr;
          interval_next_s = IV_W'(COMMAND_INTERVAL - 1);
          if (cmd) begin
            // Beat 0 is written on the acceptance edge itself.
            wr_en_s      = 1'b1;
            wr_addr_s    = addr;
            beat_next_s  = BEAT_W'(1);
            state_next_s = ST_WRITE_BURST;
          end else begin
            lat_next_s   = LAT_W'(READ_LATENCY - 1);
            state_next_s = ST_READ_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (lat_r == {LAT_W{1'b0}}) begin
          rd_en_s      = 1'b1;
          rd_addr_s    = addr_r;
          valid_next_s = 1'b1;
          beat_next_s  = BEAT_W'(1);
          state_next_s = ST_READ_BURST;
        end else begin
          lat_next_s = lat_r - LAT_W'(1);
        end
      end
      ST_READ_BURST: begin
        if (beat_r == BEAT_W'(BURST_BEATS)) begin
          valid_next_s = 1'b0;
          beat_next_s  = {BEAT_W{1'b0}};
          state_next_s = ST_IDLE;
        end else begin
          rd_en_s     = 1'b1;
          rd_addr_s   = addr_r + DEPTH_BITWIDTH'(beat_r);
          beat_next_s = beat_r + BEAT_W'(1);
        end
      end
      ST_WRITE_BURST: begin
        wr_en_s   = 1'b1;
        wr_addr_s = addr_r + DEPTH_BITWIDTH'(beat_r);
        if (beat_r == BEAT_W'(BURST_BEATS - 1)) begin
          beat_next_s  = {BEAT_W{1'b0}};
          state_next_s = ST_IDLE;
        end else begin
          beat_next_s = beat_r + BEAT_W'(1);
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE) || (interval_next_s != {IV_W{1'b0}}) || !init_calib_next_s;
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      init_cnt_r   <= {INIT_W{1'b0}};
      beat_r       <= {BEAT_W{1'b0}};
      lat_r        <= {LAT_W{1'b0}};
      interval_r   <= {IV_W{1'b0}};
      addr_r       <= {DEPTH_BITWIDTH{1'b0}};
      init_calib_r <= 1'b0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b1;
      cmd_error_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      init_cnt_r   <= init_cnt_next_s;
      beat_r       <= beat_next_s;
      lat_r        <= lat_next_s;
      interval_r   <= interval_next_s;
      addr_r       <= addr_next_s;
      init_calib_r <= init_calib_next_s;
      valid_r      <= valid_next_s;
      busy_r       <= busy_next_s;
      cmd_error_r  <= cmd_error_next_s;
    end
  end

  // Read data register; holds its last beat while no burst is returning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 64'h0;
    end else if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  // Storage array; never cleared, writes are gated off by the reset state.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
`ifdef BURST_RAM_DATA_MASK_EN
      mem_r[wr_addr_s] <= merge_masked(mem_r[wr_addr_s], wr_data, data_mask);
`else
      mem_r[wr_addr_s] <= wr_data;
`endif
    end
  end

  assign rd_data       = rd_data_r;
  assign rd_data_valid = valid_r;
  assign init_calib    = init_calib_r;
  assign busy          = busy_r;
  assign cmd_error     = cmd_error_r;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed self-checking bench for burst_ram_responder: calibration, burst timing,
// command interval, address wrap, mid-burst reset and the data-mask build option.
module tb_burst_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;
  logic        busy;
  logic        cmd_error;

  int checks;
  int errors;

  burst_ram_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .init_calib    (init_calib),
    .busy          (busy),
    .cmd_error     (cmd_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_calib(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (init_calib) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic write_burst(input logic [20:0] a, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
    cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d0;
    step();
    cmd_en = 1'b0; wr_data = d1;
    step();
    wr_data = d2;
    step();
    wr_data = d3;
    step();
    wr_data = 64'h0;
  endtask

  task automatic capture_read(input logic [20:0] a, output logic [255:0] beats,
                              output int first_k, output int last_k, output int nvalid);
    beats = '0; first_k = -1; last_k = -1; nvalid = 0;
    cmd = 1'b0; cmd_en = 1'b1; addr = a;
    step();
    cmd_en = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (rd_data_valid) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        if (nvalid < 4) beats[nvalid*64 +: 64] = rd_data;
        nvalid++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = 21'h0; wr_data = 64'h0; data_mask = 8'h00;
    step(); step();
    checks++;
    if (rd_data !== 64'h0 || rd_data_valid !== 1'b0 || init_calib !== 1'b0 || busy !== 1'b1 || cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h v=%b ic=%b busy=%b err=%b want 0 0 0 1 0",
               rd_data, rd_data_valid, init_calib, busy, cmd_error);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_en = 1'b1; cmd = 1'b0; addr = 21'h100;
      checks++;
      if (init_calib !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL init_cycle%0d got ic=%b busy=%b want ic=0 busy=1", i, init_calib, busy);
      end
      step();
      checks++;
      if (cmd_error !== 1'b1) begin
        errors++;
        $display("FAIL init_drop%0d got cmd_error=%b want 1", i, cmd_error);
      end
    end
    cmd_en = 1'b0;
    checks++;
    if (init_calib !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done got ic=%b busy=%b want ic=1 busy=0", init_calib, busy);
    end
    step();
    checks++;
    if (cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL init_no_error got cmd_error=%b want 0", cmd_error);
    end
  endtask

  task automatic test_write_read();
    logic [255:0] beats;
    int first_k, last_k, nvalid;
    bit ok;
    write_burst(21'h100, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_interval_busy got busy=%b want 1", busy);
    end
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL write_ready got timeout want busy=0"); end
    capture_read(21'h100, beats, first_k, last_k, nvalid);
    checks++;
    if (first_k !== 6 || last_k !== 9 || nvalid !== 4) begin
      errors++;
      $display("FAIL read_timing got first=%0d last=%0d n=%0d want 6 9 4", first_k, last_k, nvalid);
    end
    checks++;
    if (beats !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++;
      $display("FAIL read_data got %h want 4444..3333..2222..1111..", beats);
    end
    checks++;
    if (rd_data !== 64'h4444_4444_4444_4444) begin
      errors++;
      $display("FAIL read_hold got %h want 4444444444444444", rd_data);
    end
  endtask

  task automatic test_interval();
    int nvalid, first_k;
    bit ok;
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL interval_ready got timeout want busy=0"); end
    cmd = 1'b0; cmd_en = 1'b1; addr = 21'h100;
    step();
    cmd_en = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rd_data_valid) nvalid++;
    end
    checks++;
    if (nvalid !== 4) begin errors++; $display("FAIL interval_first_burst got %0d beats want 4", nvalid); end
    cmd_en = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL interval_busy13 got busy=%b want 1", busy); end
    step();
    checks++;
    if (cmd_error !== 1'b1) begin errors++; $display("FAIL interval_drop13 got cmd_error=%b want 1", cmd_error); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL interval_free14 got busy=%b want 0", busy); end
    step();
    cmd_en = 1'b0;
    checks++;
    if (cmd_error !== 1'b0) begin errors++; $display("FAIL interval_accept14 got cmd_error=%b want 0", cmd_error); end
    nvalid = 0; first_k = -1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (rd_data_valid) begin
        if (first_k < 0) first_k = k;
        nvalid++;
      end
    end
    checks++;
    if (first_k !== 6 || nvalid !== 4) begin
      errors++;
      $display("FAIL interval_second_burst got first=%0d n=%0d want 6 4", first_k, nvalid);
    end
  endtask

  task automatic test_wrap();
    logic [255:0] beats;
    int first_k, last_k, nvalid;
    bit ok;
    wait_ready(ok);
    write_burst(21'h1F_FFFE, 64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002,
                64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0004);
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL wrap_ready got timeout want busy=0"); end
    capture_read(21'h1F_FFFE, beats, first_k, last_k, nvalid);
    checks++;
    if (nvalid !== 4 || beats !== {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003,
                                   64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001}) begin
      errors++;
      $display("FAIL wrap_read got n=%0d %h want 4 beats dead..01..04", nvalid, beats);
    end
    capture_read(21'h00_0000, beats, first_k, last_k, nvalid);
    checks++;
    if (beats[127:0] !== {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003}) begin
      errors++;
      $display("FAIL wrap_low_read got %h want dead..04 dead..03", beats[127:0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] beats;
    int first_k, last_k, nvalid;
    bit ok;
    wait_ready(ok);
    cmd = 1'b0; cmd_en = 1'b1; addr = 21'h100;
    step();
    cmd_en = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    checks++;
    if (rd_data_valid !== 1'b1 || rd_data !== 64'h3333_3333_3333_3333) begin
      errors++;
      $display("FAIL midburst_beat2 got v=%b %h want 1 3333333333333333", rd_data_valid, rd_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data_valid !== 1'b0 || init_calib !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midburst_async got v=%b ic=%b busy=%b want 0 0 1", rd_data_valid, init_calib, busy);
    end
    step(); step();
    rst_n = 1'b1;
    wait_calib(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL midburst_recal got timeout want init_calib=1"); end
    capture_read(21'h100, beats, first_k, last_k, nvalid);
    checks++;
    if (nvalid !== 4 || beats !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++;
      $display("FAIL midburst_reread got n=%0d %h want original 1111..4444", nvalid, beats);
    end
  endtask

  task automatic test_mask();
    logic [255:0] beats;
    logic [63:0]  want;
    int first_k, last_k, nvalid;
    bit ok;
`ifdef BURST_RAM_DATA_MASK_EN
    want = 64'hFFFF_FFFF_0000_0000;
`else
    want = 64'h0;
`endif
    wait_ready(ok);
    data_mask = 8'h00;
    write_burst(21'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_ready(ok);
    data_mask = 8'h0F;
    write_burst(21'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    data_mask = 8'h00;
    wait_ready(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL mask_ready got timeout want busy=0"); end
    capture_read(21'h0, beats, first_k, last_k, nvalid);
    checks++;
    if (nvalid !== 4 || beats[63:0] !== want || beats[255:192] !== want) begin
      errors++;
      $display("FAIL mask_read got n=%0d b0=%h b3=%h want 4 %h", nvalid, beats[63:0], beats[255:192], want);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_interval();
    test_wrap();
    test_reset_mid_burst();
    test_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- Cycle-accurate responder for the burst RAM command interface driven by the cache: accepts read/write commands and serves or absorbs 4-beat, 64-bit bursts.
- Stands in for the PSRAM memory-interface IP in simulation and in on-chip BRAM builds.
- Models the IP's post-reset calibration, read latency, burst timing and minimum command interval, so cache timing bugs surface at block level.

Parameters:
- DEPTH_BITWIDTH, 21, address width in 8-byte words; storage is 2^DEPTH_BITWIDTH x 64 bits.
- BURST_BEATS, 4, beats per command; fixed at 4, other values unsupported.
- READ_LATENCY, 6, cycles from accepted read command to the first rd_data_valid; minimum 2.
- COMMAND_INTERVAL, 14, minimum cycles between accepted commands, counted from acceptance.
- INIT_CYCLES, 10, cycles after reset release before init_calib rises.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd  in  1  0: read, 1: write; sampled with cmd_en.
- cmd_en  in  1  command and address valid this cycle.
- addr  in  DEPTH_BITWIDTH  burst start address, in 8-byte words.
- wr_data  in  64  write beat data; beat 0 is sampled in the cmd_en cycle.
- data_mask  in  8  per-byte write mask; 1 means the byte is not written (see optional feature).
- rd_data  out  64  read beat data.
- rd_data_valid  out  1  rd_data is valid.
- init_calib  out  1  responder ready; commands are ignored while low.
- busy  out  1  high when a new command would not be accepted.
- cmd_error  out  1  one-cycle pulse when a cmd_en is dropped.

Behaviour:
- Reset (async assert, sync release):
  - rd_data=0, rd_data_valid=0, init_calib=0, busy=1, cmd_error=0.
  - State INIT; beat counter, latency counter and interval counter cleared.
  - Storage contents are NOT cleared.
  - Reset mid-burst aborts the burst immediately: no further beats are written or returned.
- States: INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST.
- INIT:
  - Counts INIT_CYCLES clocks after release, then sets init_calib=1 and moves to IDLE.
  - init_calib stays 1 until the next reset.
- Acceptance:
  - A command is accepted when cmd_en=1, state=IDLE and the interval counter is 0.
  - On acceptance, the interval counter loads COMMAND_INTERVAL-1 and decrements to 0 each cycle, independent of state.
  - busy = (state != IDLE) || (interval counter != 0) || !init_calib.
- Dropped command: cmd_en=1 while not accepted pulses cmd_error for one cycle. State, storage and outputs are otherwise unaffected.
- Address arithmetic:
  - Beat k uses address (addr + k) modulo 2^DEPTH_BITWIDTH; the wrap from the top address to 0 is legal.
  - addr is latched at acceptance.
- Write:
  - Beat 0 (wr_data at the acceptance edge) is stored at addr.
  - State goes to WRITE_BURST, which stores wr_data on the next 3 consecutive edges at addr+1..addr+3, then returns to IDLE.
  - No handshake per beat: the initiator must present data on consecutive cycles.
- Read:
  - State goes to READ_WAIT; rd_data_valid rises exactly READ_LATENCY cycles after the acceptance edge.
  - It then stays high for exactly 4 consecutive cycles in READ_BURST, with rd_data = mem[addr+k] on beat k.
  - After the last beat: rd_data_valid=0, state=IDLE.
  - rd_data holds its last value while invalid.
- Read-after-write to the same address returns the written data. Storage updates at the write edge, so any later read observes it.
- Simultaneous cmd_en with the final beat of a burst is dropped: state is not IDLE on that edge.

Optional Feature:
- BURST_RAM_DATA_MASK_EN
- Defined: each beat's write honours data_mask, sampled per beat; a masked byte keeps its previous content.
- Undefined: data_mask is ignored and all 8 bytes are written, matching the memory IP's unimplemented mask. The port remains present.

Test Plan:
- Release rst_n, cmd_en=1 at cycles 0..INIT_CYCLES-1 -> init_calib=0 and busy=1 throughout, cmd_error pulses each cycle; init_calib=1 at cycle INIT_CYCLES.
- Write addr=0x100, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles. After the interval, read addr=0x100 -> rd_data_valid high exactly 4 cycles starting acceptance+6, data in the same order.
- Read accepted at cycle T, second cmd_en at T+13 -> cmd_error pulse and no second burst; cmd_en at T+14 -> accepted.
- Write at addr=2^21-2 -> beats land at 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001; a read from 0x1FFFFE returns them in that order.
- Assert rst_n low during read beat 2 -> rd_data_valid falls asynchronously; after re-init, a read of the same address returns the original, unmodified data.
- With BURST_RAM_DATA_MASK_EN: write 0xFFFF_FFFF_FFFF_FFFF over 0, then write 0 with data_mask=0x0F -> read returns 0xFFFF_FFFF_0000_0000. Without the macro, the same sequence returns 0.
